// File: rtl/nv_blkbox_src_pkg.sv
// Shared types and helpers for the multi-channel black-box stimulus source.
package nv_blkbox_src_pkg;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned MAX_W  = 32;

    typedef enum logic [1:0] {
        MODE_ZERO = 2'd0,
        MODE_ONES = 2'd1,
        MODE_INCR = 2'd2,
        MODE_LFSR = 2'd3
    } mode_e;

    // Galois right-shift LFSR step; value and polynomial are zero-extended
    // from the caller's WIDTH, so the result only needs truncating back.
    function automatic logic [MAX_W-1:0] lfsr_next(input logic [MAX_W-1:0] val,
                                                   input logic [MAX_W-1:0] poly);
        logic [MAX_W-1:0] sh;
        sh = val >> 1;
        return val[0] ? (sh ^ poly) : sh;
    endfunction

endpackage

// File: rtl/nv_blkbox_src_chn.sv
// One stream: valid/ready FSM, pattern register and saturating beat counter.
module nv_blkbox_src_chn
    import nv_blkbox_src_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY = WIDTH'(8'hB8)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_en,
    input  logic             load_ok,
    input  logic [WIDTH-1:0] load_pd,
    input  mode_e            mode,
    input  logic             prdy,
    output logic             pvld,
    output logic [WIDTH-1:0] pd,
    output logic [CNT_W-1:0] cnt
);

    typedef enum logic {ST_IDLE = 1'b0, ST_VALID = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pd_q, pd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    assign accept = (state_q == ST_VALID) && prdy;

    // Next state, next pattern value and counter update.
    always_comb begin
        state_d = state_q;
        pd_d    = pd_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE:  if (cfg_en) state_d = ST_VALID;
            ST_VALID: if (accept && !cfg_en) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (load_ok) begin
            pd_d  = load_pd;
            cnt_d = '0;
        end else if (accept) begin
            unique case (mode)
                MODE_INCR: pd_d = pd_q + WIDTH'(1);
                MODE_LFSR: pd_d = WIDTH'(lfsr_next(MAX_W'(pd_q), MAX_W'(POLY)));
                default:   pd_d = pd_q;
            endcase
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pd_q    <= pd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pvld = (state_q == ST_VALID);
    assign pd   = pd_q;
    assign cnt  = cnt_q;

endmodule

// File: rtl/nv_blkbox_src_gen.sv
// Multi-channel deterministic stimulus / tie-off source with shared mode.
module nv_blkbox_src_gen
    import nv_blkbox_src_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHN   = 2,
    parameter logic [WIDTH-1:0] POLY = WIDTH'(8'hB8)
) (
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rstn,
    input  logic [1:0]             cfg_mode,
    input  logic [WIDTH-1:0]       cfg_seed,
    input  logic                   cfg_load,
    input  logic                   cfg_en,
    output logic                   cfg_err,
    output logic [CHN-1:0]         src_pvld,
    input  logic [CHN-1:0]         src_prdy,
    output logic [CHN*WIDTH-1:0]   src_pd,
    output logic [CHN*CNT_W-1:0]   src_cnt
);

    mode_e mode_q, mode_d;
    logic  err_q, err_d;
    logic  load_ok;

    // A load is only safe when no channel holds an outstanding beat.
    assign load_ok = cfg_load && !cfg_en && !(|src_pvld);

    // Shared mode register and sticky error for rejected loads.
    always_comb begin
        mode_d = mode_q;
        err_d  = err_q;
        if (load_ok)       mode_d = mode_e'(cfg_mode);
        else if (cfg_load) err_d  = 1'b1;
    end

    // Shared configuration registers.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            mode_q <= MODE_ZERO;
            err_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            err_q  <= err_d;
        end
    end

    assign cfg_err = err_q;

    for (genvar i = 0; i < int'(CHN); i++) begin : g_chn
        logic [WIDTH-1:0] load_pd;
        logic [WIDTH-1:0] lfsr_seed;

        assign lfsr_seed = cfg_seed ^ WIDTH'(i);

        // Per-channel start value; LFSR avoids the all-zero lock-up state.
        always_comb begin
            load_pd = '0;
            unique case (mode_e'(cfg_mode))
                MODE_ONES: load_pd = '1;
                MODE_INCR: load_pd = cfg_seed + WIDTH'(i);
                MODE_LFSR: load_pd = (lfsr_seed == '0) ? WIDTH'(1) : lfsr_seed;
                default:   load_pd = '0;
            endcase
        end

        nv_blkbox_src_chn #(
            .WIDTH (WIDTH),
            .POLY  (POLY)
        ) u_chn (
            .clk     (nvdla_core_clk),
            .rst_n   (nvdla_core_rstn),
            .cfg_en  (cfg_en),
            .load_ok (load_ok),
            .load_pd (load_pd),
            .mode    (mode_q),
            .prdy    (src_prdy[i]),
            .pvld    (src_pvld[i]),
            .pd      (src_pd[i*WIDTH +: WIDTH]),
            .cnt     (src_cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_nv_blkbox_src_gen.sv
// Directed bench for nv_blkbox_src_gen (WIDTH=8, CHN=2, POLY=B8).
module tb_nv_blkbox_src_gen;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CHN   = 2;
    localparam int unsigned CW    = 16;

    logic                 clk;
    logic                 rst_n;
    logic [1:0]           cfg_mode;
    logic [WIDTH-1:0]     cfg_seed;
    logic                 cfg_load;
    logic                 cfg_en;
    logic                 cfg_err;
    logic [CHN-1:0]       src_pvld;
    logic [CHN-1:0]       src_prdy;
    logic [CHN*WIDTH-1:0] src_pd;
    logic [CHN*CW-1:0]    src_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    nv_blkbox_src_gen #(.WIDTH(WIDTH), .CHN(CHN), .POLY(8'hB8)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rst_n),
        .cfg_mode        (cfg_mode),
        .cfg_seed        (cfg_seed),
        .cfg_load        (cfg_load),
        .cfg_en          (cfg_en),
        .cfg_err         (cfg_err),
        .src_pvld        (src_pvld),
        .src_prdy        (src_prdy),
        .src_pd          (src_pd),
        .src_cnt         (src_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_pd(input string tag, input logic [7:0] e0, input logic [7:0] e1);
        chk({tag, ".pd0"}, 32'(src_pd[7:0]), 32'(e0));
        chk({tag, ".pd1"}, 32'(src_pd[15:8]), 32'(e1));
    endtask

    task automatic chk_cnt(input string tag, input logic [15:0] e0, input logic [15:0] e1);
        chk({tag, ".cnt0"}, 32'(src_cnt[15:0]), 32'(e0));
        chk({tag, ".cnt1"}, 32'(src_cnt[31:16]), 32'(e1));
    endtask

    task automatic do_load(input logic [1:0] mode, input logic [7:0] seed);
        cfg_mode = mode;
        cfg_seed = seed;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        cfg_mode = 2'd0;
        cfg_seed = '0;
        cfg_load = 1'b0;
        cfg_en   = 1'b0;
        src_prdy = '0;
        #12;
        // reset values
        chk("rst.pvld", 32'(src_pvld), 32'h0);
        chk_pd("rst", 8'h00, 8'h00);
        chk_cnt("rst", 16'd0, 16'd0);
        chk("rst.err", 32'(cfg_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // legacy tie-off: stream zeros with no load
        cfg_en = 1'b1; src_prdy = 2'b11;
        tick();
        chk("def.pvld", 32'(src_pvld), 32'h3);
        chk_pd("def0", 8'h00, 8'h00);
        chk_cnt("def0", 16'd0, 16'd0);
        tick();
        chk_cnt("def1", 16'd1, 16'd1);
        tick();
        chk_pd("def2", 8'h00, 8'h00);
        chk_cnt("def2", 16'd2, 16'd2);
        cfg_en = 1'b0;
        tick();
        chk("def.idle", 32'(src_pvld), 32'h0);
        chk_cnt("def3", 16'd3, 16'd3);

        // INCR with wrap
        do_load(2'd2, 8'hFE);
        chk_pd("incr.load", 8'hFE, 8'hFF);
        chk_cnt("incr.load", 16'd0, 16'd0);
        chk("incr.noerr", 32'(cfg_err), 32'h0);
        cfg_en = 1'b1;
        tick(); chk_pd("incr0", 8'hFE, 8'hFF);
        tick(); chk_pd("incr1", 8'hFF, 8'h00);
        tick(); chk_pd("incr2", 8'h00, 8'h01);
        tick(); chk_pd("incr3", 8'h01, 8'h02);
        cfg_en = 1'b0;
        tick();
        chk("incr.idle", 32'(src_pvld), 32'h0);
        chk_pd("incr4", 8'h02, 8'h03);

        // LFSR sequence
        do_load(2'd3, 8'h01);
        chk_pd("lfsr.load", 8'h01, 8'h01);
        cfg_en = 1'b1;
        tick(); chk_pd("lfsr0", 8'h01, 8'h01);
        tick(); chk("lfsr1", 32'(src_pd[7:0]), 32'hB8);
        tick(); chk("lfsr2", 32'(src_pd[7:0]), 32'h5C);
        tick(); chk("lfsr3", 32'(src_pd[7:0]), 32'h2E);
        cfg_en = 1'b0;
        tick(); chk("lfsr4", 32'(src_pd[7:0]), 32'h17);
        do_load(2'd3, 8'h00);
        chk_pd("lfsr.zseed", 8'h01, 8'h01);

        // backpressure on ch1 while ch0 streams
        do_load(2'd2, 8'h10);
        cfg_en = 1'b1; src_prdy = 2'b01;
        tick();
        chk("bp.pvld0", 32'(src_pvld), 32'h3);
        chk_pd("bp0", 8'h10, 8'h11);
        repeat (5) tick();
        chk_pd("bp5", 8'h15, 8'h11);
        chk("bp.pvld5", 32'(src_pvld), 32'h3);
        cfg_en = 1'b0;
        tick();
        chk("bp.hold", 32'(src_pvld), 32'h2);
        chk_pd("bp6", 8'h16, 8'h11);
        src_prdy = 2'b11;
        tick();
        chk("bp.drop", 32'(src_pvld), 32'h0);
        chk_pd("bp7", 8'h16, 8'h12);
        chk_cnt("bp7", 16'd6, 16'd1);

        // illegal load while busy, then simultaneous load+enable
        cfg_en = 1'b1; src_prdy = 2'b00;
        tick();
        chk_pd("ill.pre", 8'h16, 8'h12);
        do_load(2'd0, 8'h00);
        chk("ill.err", 32'(cfg_err), 32'h1);
        chk_pd("ill.hold", 8'h16, 8'h12);
        chk("ill.pvld", 32'(src_pvld), 32'h3);
        src_prdy = 2'b11;
        tick();
        chk_pd("ill.mode", 8'h17, 8'h13);
        cfg_en = 1'b0;
        tick();
        chk_pd("ill.idle", 8'h18, 8'h14);
        cfg_en = 1'b1; cfg_mode = 2'd1; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        chk("sim.pvld", 32'(src_pvld), 32'h3);
        chk_pd("sim", 8'h18, 8'h14);
        cfg_en = 1'b0;
        tick();
        chk("sim.err", 32'(cfg_err), 32'h1);

        // counter saturation
        do_load(2'd2, 8'h00);
        chk("sat.err", 32'(cfg_err), 32'h1);
        cfg_en = 1'b1; src_prdy = 2'b11;
        repeat (65536) tick();
        chk_cnt("sat", 16'hFFFF, 16'hFFFF);
        repeat (3) tick();
        chk_cnt("sat3", 16'hFFFF, 16'hFFFF);
        chk_pd("sat3", 8'h02, 8'h03);

        // asynchronous reset mid-beat
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.pvld", 32'(src_pvld), 32'h0);
        chk_pd("arst", 8'h00, 8'h00);
        chk_cnt("arst", 16'd0, 16'd0);
        chk("arst.err", 32'(cfg_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_pd("arst.z0", 8'h00, 8'h00);
        tick();
        chk_pd("arst.z1", 8'h00, 8'h00);
        chk_cnt("arst.z1", 16'd1, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
